// File: rtl/print_module.sv
// Sprite hit test and sprite-memory address generator, one pass per pixel strobe.
// Each pass runs IDLE -> LATCH -> COMPUTE -> OUTPUT on the 100 MHz clock.
`timescale 1ns/1ps
module print_module #(
  parameter int SPRITE_SIZE = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_pixel,
  input  logic [31:0] data_reg,
  input  logic        active_area,
  input  logic [8:0]  pixel_x,
  input  logic [8:0]  pixel_y,
  output logic [16:0] address_memory,
  output logic        printtingScreen,
  output logic [17:0] check_value
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LATCH   = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_OUTPUT  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        clk_pixel_q;
  logic        pixel_event;

  logic        en_q, act_q;
  logic [8:0]  x_q, y_q, px_q, py_q;
  logic [12:0] base_q;
  logic        hit_q, hit_d;
  logic [16:0] addr_q, addr_d;

  logic [16:0] address_memory_q;
  logic        printing_q;
  logic [17:0] check_value_q;

  // Rising edge of the pixel strobe, seen through its one-clock history.
  assign pixel_event = clk_pixel & ~clk_pixel_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      clk_pixel_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_pixel_q <= clk_pixel;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (pixel_event) state_d = ST_LATCH;
      ST_LATCH:   state_d = ST_COMPUTE;
      ST_COMPUTE: state_d = ST_OUTPUT;
      ST_OUTPUT:  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Bounds are compared in 10 bits so X+SPRITE_SIZE-1 cannot wrap past 511.
  logic [9:0] x_lo, x_hi, y_lo, y_hi, px_w, py_w, row_w, col_w;

  always_comb begin
    x_lo   = {1'b0, x_q};
    y_lo   = {1'b0, y_q};
    x_hi   = x_lo + 10'(SPRITE_SIZE - 1);
    y_hi   = y_lo + 10'(SPRITE_SIZE - 1);
    px_w   = {1'b0, px_q};
    py_w   = {1'b0, py_q};
    row_w  = py_w - y_lo;
    col_w  = px_w - x_lo;
    hit_d  = en_q & act_q & (px_w >= x_lo) & (px_w <= x_hi)
                          & (py_w >= y_lo) & (py_w <= y_hi);
    addr_d = 17'(base_q) + 17'(row_w) * 17'(SPRITE_SIZE) + 17'(col_w);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      en_q             <= 1'b0;
      act_q            <= 1'b0;
      x_q              <= '0;
      y_q              <= '0;
      px_q             <= '0;
      py_q             <= '0;
      base_q           <= '0;
      hit_q            <= 1'b0;
      addr_q           <= '0;
      address_memory_q <= '0;
      printing_q       <= 1'b0;
      check_value_q    <= '0;
    end else begin
      case (state_q)
        ST_LATCH: begin
          en_q   <= data_reg[31];
          x_q    <= data_reg[30:22];
          y_q    <= data_reg[21:13];
          base_q <= data_reg[12:0];
          act_q  <= active_area;
          px_q   <= pixel_x;
          py_q   <= pixel_y;
        end
        ST_COMPUTE: begin
          hit_q  <= hit_d;
          addr_q <= addr_d;
        end
        ST_OUTPUT: begin
          address_memory_q <= hit_q ? addr_q : 17'd0;
          printing_q       <= hit_q;
          check_value_q    <= {py_q, px_q};
        end
        default: ;
      endcase
    end
  end

  assign address_memory  = address_memory_q;
  assign printtingScreen = printing_q;
  assign check_value     = check_value_q;

endmodule

// File: tb/tb_print_module.sv
// Bench for print_module: directed vector table, hand-written timing/reset
// sequences and randomized pixels checked against a reference model.
`timescale 1ns/1ps
module tb_print_module;

  localparam int SZ = 20;

  logic        clk;
  logic        reset;
  logic        clk_pixel;
  logic [31:0] data_reg;
  logic        active_area;
  logic [8:0]  pixel_x, pixel_y;
  logic [16:0] address_memory;
  logic        printtingScreen;
  logic [17:0] check_value;

  int n_cmp = 0;
  int n_err = 0;

  print_module #(.SPRITE_SIZE(SZ)) dut (
    .clk             (clk),
    .reset           (reset),
    .clk_pixel       (clk_pixel),
    .data_reg        (data_reg),
    .active_area     (active_area),
    .pixel_x         (pixel_x),
    .pixel_y         (pixel_y),
    .address_memory  (address_memory),
    .printtingScreen (printtingScreen),
    .check_value     (check_value)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "timeout");
  end

  // ---------------- types / model ----------------
  typedef struct {
    logic [31:0] d;
    logic        act;
    logic [8:0]  px;
    logic [8:0]  py;
    logic [16:0] ea;
    logic        eps;
  } vec_t;

  typedef struct {
    logic [16:0] addr;
    logic        ps;
    logic [17:0] cv;
  } exp_t;

  function automatic logic [31:0] mk(input logic en, input logic [8:0] x,
                                     input logic [8:0] y, input logic [12:0] b);
    return {en, x, y, b};
  endfunction

  // Straight from the sprite rules with integer arithmetic.
  function automatic exp_t model(input logic [31:0] d, input logic act,
                                 input logic [8:0] px, input logic [8:0] py);
    exp_t m;
    int x, y, b, ix, iy;
    bit hit;
    x  = int'(d[30:22]);
    y  = int'(d[21:13]);
    b  = int'(d[12:0]);
    ix = int'(px);
    iy = int'(py);
    hit = d[31] && act && (ix >= x) && (ix <= x + SZ - 1)
                       && (iy >= y) && (iy <= y + SZ - 1);
    m.addr = hit ? 17'((b + (iy - y) * SZ + (ix - x)) % 131072) : 17'd0;
    m.ps   = hit;
    m.cv   = {py, px};
    return m;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  task automatic check_out(input string name, input logic [16:0] ea,
                           input logic eps, input logic [17:0] ecv);
    check({name, ".addr"}, 32'(address_memory), 32'(ea));
    check({name, ".print"}, 32'(printtingScreen), 32'(eps));
    check({name, ".check"}, 32'(check_value), 32'(ecv));
  endtask

  // ---------------- drivers ----------------
  task automatic set_inputs(input logic [31:0] d, input logic act,
                            input logic [8:0] px, input logic [8:0] py);
    data_reg    = d;
    active_area = act;
    pixel_x     = px;
    pixel_y     = py;
  endtask

  task automatic scramble_inputs();
    set_inputs($urandom, 1'($urandom), 9'($urandom), 9'($urandom));
  endtask

  // One full pixel pass; inputs are scrambled right after the LATCH edge so
  // the result must come from the sample taken at that edge. Returns at the
  // negedge following the OUTPUT edge.
  task automatic run_pixel(input logic [31:0] d, input logic act,
                           input logic [8:0] px, input logic [8:0] py);
    @(negedge clk);
    set_inputs(d, act, px, py);
    clk_pixel = 1'b1;
    @(negedge clk);             // event edge
    @(negedge clk);             // LATCH edge
    clk_pixel = 1'b0;
    scramble_inputs();
    @(negedge clk);             // COMPUTE edge
    @(negedge clk);             // OUTPUT edge
  endtask

  task automatic wait_neg(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  vec_t vecs[12];
  logic [31:0] spr;

  initial begin
    spr = mk(1'b1, 9'd100, 9'd50, 13'd0);
    vecs[0]  = '{spr, 1'b1, 9'd105, 9'd53, 17'd65,   1'b1};
    vecs[1]  = '{spr, 1'b1, 9'd119, 9'd69, 17'd399,  1'b1};
    vecs[2]  = '{spr, 1'b1, 9'd120, 9'd69, 17'd0,    1'b0};
    vecs[3]  = '{spr, 1'b1, 9'd119, 9'd70, 17'd0,    1'b0};
    vecs[4]  = '{spr, 1'b1, 9'd100, 9'd50, 17'd0,    1'b1};
    vecs[5]  = '{spr, 1'b1, 9'd99,  9'd50, 17'd0,    1'b0};
    vecs[6]  = '{spr, 1'b1, 9'd100, 9'd49, 17'd0,    1'b0};
    vecs[7]  = '{mk(1'b1, 9'd0, 9'd0, 13'd1000), 1'b1, 9'd0, 9'd0, 17'd1000, 1'b1};
    vecs[8]  = '{spr, 1'b0, 9'd105, 9'd53, 17'd0,    1'b0};
    vecs[9]  = '{mk(1'b0, 9'd100, 9'd50, 13'd0), 1'b1, 9'd105, 9'd53, 17'd0, 1'b0};
    vecs[10] = '{mk(1'b1, 9'd500, 9'd500, 13'd8191), 1'b1, 9'd511, 9'd511, 17'd8422, 1'b1};
    vecs[11] = '{mk(1'b1, 9'd492, 9'd0, 13'd7), 1'b1, 9'd511, 9'd19, 17'd406, 1'b1};

    // ---- reset: hold 4 cycles, outputs cleared and stay 0 until an event ----
    reset     = 1'b0;
    clk_pixel = 1'b0;
    set_inputs(32'd0, 1'b0, 9'd0, 9'd0);
    wait_neg(4);
    check_out("reset", 17'd0, 1'b0, 18'd0);
    reset = 1'b1;
    set_inputs(spr, 1'b1, 9'd105, 9'd53);
    wait_neg(6);
    check_out("post_reset_idle", 17'd0, 1'b0, 18'd0);

    // ---- first event latency: not updated after COMPUTE, updated after OUTPUT ----
    clk_pixel = 1'b1;
    @(negedge clk);             // event edge
    @(negedge clk);             // LATCH edge
    clk_pixel = 1'b0;
    set_inputs(mk(1'b1, 9'd0, 9'd0, 13'd3000), 1'b1, 9'd1, 9'd1);
    @(negedge clk);             // COMPUTE edge
    check_out("latency_early", 17'd0, 1'b0, 18'd0);
    @(negedge clk);             // OUTPUT edge
    check_out("latency_update", 17'd65, 1'b1, {9'd53, 9'd105});
    wait_neg(3);
    check_out("hold", 17'd65, 1'b1, {9'd53, 9'd105});

    // ---- vector table ----
    for (int i = 0; i < 12; i++) begin
      run_pixel(vecs[i].d, vecs[i].act, vecs[i].px, vecs[i].py);
      check_out($sformatf("vec%0d", i), vecs[i].ea, vecs[i].eps, {vecs[i].py, vecs[i].px});
    end

    // ---- strobe edge during a pass is ignored ----
    @(negedge clk);
    set_inputs(spr, 1'b1, 9'd105, 9'd53);
    clk_pixel = 1'b1;
    @(negedge clk);             // event edge
    clk_pixel = 1'b0;
    @(negedge clk);             // LATCH edge
    clk_pixel = 1'b1;           // second rising strobe while busy
    set_inputs(spr, 1'b1, 9'd110, 9'd55);
    wait_neg(2);                // COMPUTE, OUTPUT
    check_out("busy_first", 17'd65, 1'b1, {9'd53, 9'd105});
    wait_neg(4);
    clk_pixel = 1'b0;
    wait_neg(4);
    check_out("busy_ignored", 17'd65, 1'b1, {9'd53, 9'd105});

    // ---- reset mid-pass aborts the update ----
    @(negedge clk);
    set_inputs(spr, 1'b1, 9'd119, 9'd69);
    clk_pixel = 1'b1;
    @(negedge clk);             // event edge
    @(negedge clk);             // LATCH edge
    reset     = 1'b0;
    clk_pixel = 1'b0;
    @(negedge clk);
    check_out("midreset_clear", 17'd0, 1'b0, 18'd0);
    reset = 1'b1;
    wait_neg(6);
    check_out("midreset_abort", 17'd0, 1'b0, 18'd0);
    run_pixel(vecs[1].d, vecs[1].act, vecs[1].px, vecs[1].py);
    check_out("midreset_resume", 17'd399, 1'b1, {9'd69, 9'd119});

    // ---- randomized pixels against the model ----
    for (int i = 0; i < 80; i++) begin
      logic [31:0] d;
      logic        act;
      logic [8:0]  px, py;
      exp_t        m;
      d   = {1'($urandom_range(0, 7) != 0), 9'($urandom), 9'($urandom), 13'($urandom)};
      act = 1'($urandom_range(0, 7) != 0);
      px  = 9'(int'(d[30:22]) + int'($urandom_range(0, 22)) - 1);
      py  = 9'(int'(d[21:13]) + int'($urandom_range(0, 22)) - 1);
      if ($urandom_range(0, 9) == 0) px = 9'($urandom);
      m = model(d, act, px, py);
      run_pixel(d, act, px, py);
      check_out($sformatf("rand%0d", i), m.addr, m.ps, m.cv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/print_module.md
PRINT_MODULE -- requirements
Module: print_module

Interface
REQ-001 clk  input  1  system clock, 100 MHz; the only clock; all state changes on its rising edge.
REQ-002 reset  input  1  synchronous, active-low reset; sampled on rising clk.
REQ-003 clk_pixel  input  1  25 MHz pixel strobe; treated as data sampled by clk, never used as a clock.
REQ-004 data_reg  input  32  sprite descriptor: [31] enable, [30:22] sprite X, [21:13] sprite Y, [12:0] sprite base address.
REQ-005 active_area  input  1  high when the current pixel is inside the visible screen area.
REQ-006 pixel_x  input  9  current pixel column.
REQ-007 pixel_y  input  9  current pixel row.
REQ-008 address_memory  output  17  sprite-memory address of the pixel being printed.
REQ-009 printtingScreen  output  1  high when the current pixel belongs to the sprite.
REQ-010 check_value  output  18  debug value {pixel_y, pixel_x} latched for the current decision.
REQ-011 Parameter SPRITE_SIZE, default 20: sprite width and height in pixels.

Function
REQ-012 clk_pixel is registered each clk; a pixel event occurs when the registered value is 0 and the current clk_pixel is 1.
REQ-013 FSM states: IDLE, LATCH, COMPUTE, OUTPUT.
REQ-014 IDLE -> LATCH on a pixel event; otherwise stay in IDLE.
REQ-015 LATCH: capture data_reg, active_area, pixel_x, pixel_y into internal registers.
REQ-016 LATCH -> COMPUTE unconditionally.
REQ-017 COMPUTE: set hit = enable & active_area & (X <= px <= X+SPRITE_SIZE-1) & (Y <= py <= Y+SPRITE_SIZE-1).
REQ-018 COMPUTE: all bound comparisons use 10-bit unsigned arithmetic, so X+19 never wraps.
REQ-019 COMPUTE -> OUTPUT unconditionally.
REQ-020 OUTPUT, hit: address_memory = base + (py-Y)*SPRITE_SIZE + (px-X), truncated to 17 bits (mod 2^17).
REQ-021 OUTPUT, hit: printtingScreen = 1.
REQ-022 OUTPUT, no hit: address_memory = 0 and printtingScreen = 0.
REQ-023 OUTPUT, both cases: check_value = {latched pixel_y, latched pixel_x}.
REQ-024 OUTPUT -> IDLE; the outputs hold until the next OUTPUT state updates them.
REQ-025 Latency: outputs update on the 4th rising clk edge after the edge that detects the pixel event (event edge, LATCH, COMPUTE, OUTPUT).
REQ-026 The input sample is taken at the LATCH edge; input changes after that edge do not affect the current decision.
REQ-027 The full pass completes within one clk_pixel period, so no pixel event is missed.
REQ-028 A pixel event that occurs while the FSM is not in IDLE is ignored.
REQ-029 Unknown (X) inputs need no defined handling; outputs are only checked after known inputs are sampled.

Reset
REQ-030 While reset = 0 at a rising clk: FSM -> IDLE, address_memory = 0, printtingScreen = 0, check_value = 0, clk_pixel history register = 0.
REQ-031 Reset asserted mid-operation aborts the pass; no OUTPUT update occurs for that pixel.
REQ-032 Operation resumes at the first pixel event after reset = 1.

Verification
REQ-033 Inside hit: data_reg enable=1, X=100, Y=50, base=0; pixel (105,53); active=1 -> address_memory=65, printtingScreen=1, check_value={9'd53,9'd105}.
REQ-034 Edge: same sprite, pixel (119,69) -> address_memory=399, printtingScreen=1; pixel (120,69) -> address_memory=0, printtingScreen=0.
REQ-035 Base offset: base=1000, X=0, Y=0, pixel (0,0) -> address_memory=1000, printtingScreen=1.
REQ-036 Masking: active_area=0 or enable=0 with an in-bounds pixel -> printtingScreen=0, address_memory=0, check_value still updated.
REQ-037 Reset: hold reset=0 for 4 clk cycles, then release -> all outputs 0 until the first pixel event; first update occurs 4 clk edges after that event.
REQ-038 Timing: verify that a data_reg change after the LATCH edge does not alter that pixel's result.
